// File: rtl/axi_wr_master_split.sv
// AXI4 write master that splits one user write request into bursts of at most
// MAX_BURST beats, never crossing a 2^COL_BITS-word row boundary.
module axi_wr_master_split #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned COL_BITS   = 10,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter logic [3:0]  AXI_ID     = 4'hF,
  parameter logic [2:0]  AXSIZE     = 3'd2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_end,
  input  logic                    wr_trig,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [CNT_WIDTH-1:0]    wr_beats,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_data_en,
  output logic                    wr_ready,
  output logic                    wr_done,
  output logic                    wr_err,
  output logic [3:0]              axi_awid,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic [2:0]              axi_awsize,
  output logic [1:0]              axi_awburst,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  input  logic                    axi_bvalid,
  input  logic [1:0]              axi_bresp,
  output logic                    axi_bready
);

  // Burst length fits 9 bits (MAX_BURST <= 256); compare in a width wide enough for all terms.
  localparam int unsigned LEN_W = 9;
  localparam int unsigned MAX_A = (CNT_WIDTH > COL_BITS + 1) ? CNT_WIDTH : COL_BITS + 1;
  localparam int unsigned CMP_W = (MAX_A > LEN_W) ? MAX_A : LEN_W;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAw   = 3'd1;
  localparam logic [2:0] StW    = 3'd2;
  localparam logic [2:0] StB    = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  rem_q;
  logic [7:0]            beat_q;
  logic [LEN_W-1:0]      len_q;
  logic                  awvalid_q, wvalid_q, err_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;

  logic [ADDR_WIDTH-1:0] calc_addr;
  logic [CNT_WIDTH-1:0]  calc_rem;
  logic [COL_BITS:0]     room;
  logic [CMP_W-1:0]      l_min;
  logic [LEN_W-1:0]      burst_len;
  logic [7:0]            burst_awlen;

  logic req_go, aw_hs, w_beat, w_last, b_hs, more;

  // In IDLE the first burst is sized from the request inputs, otherwise from the running state.
  always_comb begin
    calc_addr = (state_q == StIdle) ? wr_addr : addr_q;
    calc_rem  = (state_q == StIdle) ? wr_beats : rem_q;
    room      = {1'b1, {COL_BITS{1'b0}}} - {1'b0, calc_addr[COL_BITS-1:0]};
    l_min     = CMP_W'(calc_rem);
    if (CMP_W'(MAX_BURST) < l_min) l_min = CMP_W'(MAX_BURST);
    if (CMP_W'(room) < l_min) l_min = CMP_W'(room);
    burst_len   = LEN_W'(l_min);
    burst_awlen = 8'(burst_len - LEN_W'(1));
  end

  assign req_go = (state_q == StIdle) & wr_trig & init_end & (wr_beats != '0);
  assign aw_hs  = (state_q == StAw) & awvalid_q & axi_awready;
  assign w_beat = (state_q == StW) & wvalid_q & axi_wready;
  assign w_last = w_beat & (beat_q == 8'd0);
  assign b_hs   = (state_q == StB) & axi_bvalid;
  assign more   = (rem_q != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_go) state_d = StAw;
      StAw:    if (aw_hs) state_d = StW;
      StW:     if (w_last) state_d = StB;
      StB:     if (axi_bvalid) state_d = more ? StAw : StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rem_q     <= '0;
      beat_q    <= '0;
      len_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
    end else begin
      state_q <= state_d;
      if (req_go) begin
        addr_q    <= wr_addr;
        rem_q     <= wr_beats;
        err_q     <= 1'b0;
        len_q     <= burst_len;
        awaddr_q  <= wr_addr;
        awlen_q   <= burst_awlen;
        awvalid_q <= 1'b1;
      end
      if (aw_hs) begin
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b1;
        beat_q    <= awlen_q;
      end
      if (w_beat) begin
        if (beat_q == 8'd0) begin
          wvalid_q <= 1'b0;
          addr_q   <= addr_q + ADDR_WIDTH'(len_q);
          rem_q    <= rem_q - CNT_WIDTH'(len_q);
        end else begin
          beat_q <= beat_q - 8'd1;
        end
      end
      if (b_hs) begin
        if (axi_bresp != 2'b00) err_q <= 1'b1;
        // Next burst is issued straight from B so there is no idle cycle between bursts.
        if (more) begin
          len_q     <= burst_len;
          awaddr_q  <= addr_q;
          awlen_q   <= burst_awlen;
          awvalid_q <= 1'b1;
        end
      end
    end
  end

  assign wr_data_en  = axi_wvalid & axi_wready;
  assign wr_ready    = (state_q == StIdle) & init_end;
  assign wr_done     = (state_q == StDone);
  assign wr_err      = err_q;
  assign axi_awid    = AXI_ID;
  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awsize  = AXSIZE;
  assign axi_awburst = 2'b01;
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = wr_data;
  assign axi_wstrb   = '1;
  assign axi_wlast   = wvalid_q & (beat_q == 8'd0);
  assign axi_bready  = (state_q == StB);

endmodule

// File: tb/tb_axi_wr_master_split.sv
// Randomised bench for axi_wr_master_split: a queue-based burst model and a
// stalling AXI slave check addresses, lengths, data order, wlast and status.
module tb_axi_wr_master_split;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int CB = 10;
  localparam int MB = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_end = 1'b0;
  logic          wr_trig = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_beats = '0;
  logic [DW-1:0] wr_data;
  logic          wr_data_en, wr_ready, wr_done, wr_err;
  logic [3:0]    axi_awid;
  logic          axi_awvalid;
  logic          axi_awready = 1'b0;
  logic [AW-1:0] axi_awaddr;
  logic [7:0]    axi_awlen;
  logic [2:0]    axi_awsize;
  logic [1:0]    axi_awburst;
  logic          axi_wvalid;
  logic          axi_wready = 1'b0;
  logic [DW-1:0] axi_wdata;
  logic [3:0]    axi_wstrb;
  logic          axi_wlast;
  logic          axi_bvalid = 1'b0;
  logic [1:0]    axi_bresp = 2'b00;
  logic          axi_bready;

  axi_wr_master_split dut (
    .clk(clk), .rst_n(rst_n), .init_end(init_end), .wr_trig(wr_trig), .wr_addr(wr_addr),
    .wr_beats(wr_beats), .wr_data(wr_data), .wr_data_en(wr_data_en), .wr_ready(wr_ready),
    .wr_done(wr_done), .wr_err(wr_err), .axi_awid(axi_awid), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast), .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp),
    .axi_bready(axi_bready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected bursts, derived from the splitting rule with plain integer arithmetic.
  logic [AW-1:0] exp_addr_q[$];
  int            exp_len_q[$];

  task automatic build_model(input logic [AW-1:0] a, input int beats);
    longint addr = longint'(a);
    int rem = beats;
    int room, len;
    exp_addr_q.delete();
    exp_len_q.delete();
    while (rem > 0) begin
      room = (1 << CB) - int'(addr % (1 << CB));
      len  = rem;
      if (MB < len) len = MB;
      if (room < len) len = room;
      exp_addr_q.push_back(AW'(addr));
      exp_len_q.push_back(len);
      addr = (addr + len) % (longint'(1) << AW);
      rem -= len;
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] s, input int i);
    return s ^ (32'(i) * 32'h9E3779B9) ^ 32'(i);
  endfunction

  logic [31:0] seed = 32'h0;
  int  pop_cnt = 0, w_idx = 0, b_idx = 0, wlast_cnt = 0, done_cnt = 0, aw_cnt = 0;
  int  cur_len = 0, beat_in = 0, err_burst = -1;
  bit  stall = 1'b0, pop_pend = 1'b0, b_pending = 1'b0;
  bit  prev_awv = 1'b0, prev_awr = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [7:0]    prev_len = '0;

  assign wr_data = data_of(seed, pop_cnt);

  // Slave side: drives ready/response after each edge with optional random stalls.
  always @(posedge clk) begin
    #1;
    if (pop_pend) pop_cnt++;
    axi_awready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    axi_wready  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    axi_bvalid  = b_pending && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
    axi_bresp   = (b_idx == err_burst) ? 2'b10 : 2'b00;
  end

  // Monitor: values at the falling edge are what the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_addr_q.delete();
      exp_len_q.delete();
      b_pending = 1'b0;
      pop_pend  = 1'b0;
      prev_awv  = 1'b0;
    end else begin
      pop_pend = wr_data_en;
      if (axi_wvalid || wr_data_en) check_eq("wr_data_en", wr_data_en, axi_wvalid & axi_wready);
      if (prev_awv && !prev_awr) begin
        check_eq("aw_hold_valid", axi_awvalid, 1);
        check_eq("aw_hold_addr", axi_awaddr, prev_addr);
        check_eq("aw_hold_len", axi_awlen, prev_len);
      end
      if (axi_awvalid) check_eq("aw_w_overlap", axi_wvalid, 0);
      if (axi_awvalid && axi_awready) begin
        aw_cnt++;
        if (exp_addr_q.size() == 0) begin
          check_eq("aw_unexpected", 1, 0);
        end else begin
          cur_len = exp_len_q.pop_front();
          check_eq("awaddr", axi_awaddr, exp_addr_q.pop_front());
          check_eq("awlen", axi_awlen, 64'(cur_len - 1));
          beat_in = 0;
        end
      end
      if (axi_wvalid && axi_wready) begin
        check_eq("wdata", axi_wdata, data_of(seed, w_idx));
        check_eq("wlast", axi_wlast, (beat_in == cur_len - 1));
        if (axi_wlast) wlast_cnt++;
        w_idx++;
        beat_in++;
        if (beat_in == cur_len) b_pending = 1'b1;
      end
      if (axi_bready && axi_bvalid) begin
        b_pending = 1'b0;
        b_idx++;
      end
      if (wr_done) done_cnt++;
      prev_awv  = axi_awvalid;
      prev_awr  = axi_awready;
      prev_addr = axi_awaddr;
      prev_len  = axi_awlen;
    end
  end

  task automatic start_req(input logic [AW-1:0] a, input int beats, input bit st, input int errb);
    @(posedge clk);
    #2;
    build_model(a, beats);
    stall = st;
    err_burst = errb;
    seed = $urandom;
    pop_cnt = 0; w_idx = 0; b_idx = 0; wlast_cnt = 0; done_cnt = 0; aw_cnt = 0;
    check_eq("ready_idle", wr_ready, 1);
    wr_trig = 1'b1;
    wr_addr = a;
    wr_beats = CW'(beats);
    @(posedge clk);
    #2;
    wr_trig = 1'b0;
    wr_addr = AW'($urandom);
    wr_beats = CW'($urandom);
    check_eq("err_clear", wr_err, 0);
    check_eq("ready_busy", wr_ready, 0);
  endtask

  task automatic run_req(input logic [AW-1:0] a, input int beats, input bit st, input int errb,
                         input bit exp_err);
    int nb, t;
    start_req(a, beats, st, errb);
    nb = exp_addr_q.size();
    t = 0;
    while (!wr_done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_eq("done_timeout", (t < 3000), 1);
    check_eq("err_at_done", wr_err, exp_err);
    check_eq("beats_popped", pop_cnt, beats);
    check_eq("beats_seen", w_idx, beats);
    check_eq("bursts", aw_cnt, nb);
    check_eq("wlast_cnt", wlast_cnt, nb);
    check_eq("resp_cnt", b_idx, nb);
    @(negedge clk);
    check_eq("done_pulse", wr_done, 0);
    check_eq("done_cnt", done_cnt, 1);
    check_eq("err_held", wr_err, exp_err);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_awvalid", axi_awvalid, 0);
    check_eq("rst_wvalid", axi_wvalid, 0);
    check_eq("rst_done", wr_done, 0);
    check_eq("rst_err", wr_err, 0);
    check_eq("rst_awaddr", axi_awaddr, 0);
    check_eq("rst_awlen", axi_awlen, 0);
    check_eq("rst_ready", wr_ready, 0);
    rst_n = 1'b1;

    // Requests are ignored before DRAM init completes.
    @(posedge clk);
    #2;
    wr_trig = 1'b1; wr_addr = 26'h100; wr_beats = 16'd8;
    @(posedge clk);
    #2;
    wr_trig = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("noinit_awvalid", axi_awvalid, 0);
    check_eq("noinit_ready", wr_ready, 0);
    check_eq("noinit_aw_cnt", aw_cnt, 0);
    check_eq("awid", axi_awid, 4'hF);
    check_eq("awsize", axi_awsize, 3'd2);
    check_eq("awburst", axi_awburst, 2'b01);
    check_eq("wstrb", axi_wstrb, 4'hF);
    init_end = 1'b1;

    run_req(26'h100, 8, 1'b0, -1, 1'b0);
    run_req(26'h3F8, 40, 1'b0, -1, 1'b0);
    run_req(26'h2A5, 1, 1'b0, -1, 1'b0);
    run_req(26'h1000, 33, 1'b1, -1, 1'b0);
    run_req(26'h3FFFFF4, 20, 1'b0, -1, 1'b0);

    // Error response on the middle burst; status must survive to the next request.
    run_req(26'h3F8, 40, 1'b1, 1, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("err_sticky", wr_err, 1);
    run_req(26'h10, 5, 1'b0, -1, 1'b0);

    // Zero-beat request is dropped.
    @(posedge clk);
    #2;
    aw_cnt = 0;
    wr_trig = 1'b1; wr_beats = '0; wr_addr = 26'h40;
    @(posedge clk);
    #2;
    wr_trig = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("zero_awvalid", axi_awvalid, 0);
    check_eq("zero_aw_cnt", aw_cnt, 0);
    check_eq("zero_ready", wr_ready, 1);

    for (int i = 0; i < 12; i++) begin
      run_req(AW'($urandom), int'($urandom_range(1, 70)), bit'($urandom_range(0, 1)),
              (i % 3 == 0) ? 0 : -1, (i % 3 == 0));
    end

    // Synchronous reset in the middle of a data burst.
    start_req(26'h3F8, 40, 1'b0, -1);
    t = 0;
    while (w_idx < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("mid_wait_timeout", (t < 200), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    check_eq("mid_rst_awvalid", axi_awvalid, 0);
    check_eq("mid_rst_wvalid", axi_wvalid, 0);
    check_eq("mid_rst_data_en", wr_data_en, 0);
    check_eq("mid_rst_bready", axi_bready, 0);
    check_eq("mid_rst_done", wr_done, 0);
    check_eq("mid_rst_err", wr_err, 0);
    check_eq("mid_rst_awaddr", axi_awaddr, 0);
    check_eq("mid_rst_awlen", axi_awlen, 0);
    check_eq("mid_rst_ready", wr_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check_eq("post_rst_ready", wr_ready, 1);
    check_eq("post_rst_awvalid", axi_awvalid, 0);
    run_req(26'h3F0, 24, 1'b1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
